// File: rtl/ay_write_arbiter_pkg.sv
// Shared types and widths for the AY-3-891x write arbiter.
package ay_write_arbiter_pkg;

    localparam int PSG_REG_W  = 4;
    localparam int PSG_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_GAP  = 2'd3
    } state_e;

endpackage

// File: rtl/ay_write_arbiter_rr.sv
// Two-way round-robin grant; last_grant advances only when update_en grants.
module rr_arbiter2 (
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       update_en,
    output logic [1:0] grant,
    output logic       last_grant
);

    logic last_grant_q, last_grant_d;

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        grant        = 2'b00;
        last_grant_d = last_grant_q;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
        if (update_en && (|req)) begin
            last_grant_d = grant[1];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

    assign last_grant = last_grant_q;

endmodule

// File: rtl/ay_write_arbiter.sv
// Arbitrates CPU and sequencer register writes into the PSG's two-tick
// address/data bus sequence, skipping the address tick when already latched.
module ay_write_arbiter
    import ay_write_arbiter_pkg::*;
#(
    parameter bit          SKIP_ADDR = 1'b1,
    parameter int unsigned GAP       = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req0_valid,
    input  logic [PSG_REG_W-1:0]  req0_addr,
    input  logic [PSG_DATA_W-1:0] req0_data,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [PSG_REG_W-1:0]  req1_addr,
    input  logic [PSG_DATA_W-1:0] req1_data,
    output logic                  req1_ready,
    output logic                  a0,
    output logic                  wr_tick,
    output logic [PSG_DATA_W-1:0] wdata,
    output logic                  busy
);

    localparam logic [3:0] GAP_LOAD = (GAP > 0) ? 4'(GAP - 1) : 4'd0;

    state_e                state_q, state_d;
    logic [PSG_REG_W-1:0]  addr_q, addr_d;
    logic [PSG_DATA_W-1:0] data_q, data_d;
    logic [PSG_REG_W-1:0]  shadow_addr_q, shadow_addr_d;
    logic                  shadow_valid_q, shadow_valid_d;
    logic [3:0]            gap_cnt_q, gap_cnt_d;
    logic                  a0_q, a0_d;
    logic                  wr_tick_q, wr_tick_d;
    logic [PSG_DATA_W-1:0] wdata_q, wdata_d;

    logic                  grant_en;
    logic [1:0]            gnt;
    logic                  last_grant;
    logic [PSG_REG_W-1:0]  gnt_addr;
    logic [PSG_DATA_W-1:0] gnt_data;

    rr_arbiter2 u_rr (
        .clk        (clk),
        .reset      (reset),
        .req        ({req1_valid, req0_valid}),
        .update_en  (grant_en),
        .grant      (gnt),
        .last_grant (last_grant)
    );

    assign grant_en   = (state_q == ST_IDLE);
    assign req0_ready = grant_en & gnt[0];
    assign req1_ready = grant_en & gnt[1];
    assign gnt_addr   = gnt[1] ? req1_addr : req0_addr;
    assign gnt_data   = gnt[1] ? req1_data : req0_data;

    // Bus outputs are computed from the state being entered, so they are
    // registered yet line up with the cycle that state occupies.
    always_comb begin
        state_d        = state_q;
        addr_d         = addr_q;
        data_d         = data_q;
        shadow_addr_d  = shadow_addr_q;
        shadow_valid_d = shadow_valid_q;
        gap_cnt_d      = gap_cnt_q;
        a0_d           = 1'b0;
        wr_tick_d      = 1'b0;
        wdata_d        = '0;
        case (state_q)
            ST_IDLE: begin
                if (|gnt) begin
                    addr_d    = gnt_addr;
                    data_d    = gnt_data;
                    wr_tick_d = 1'b1;
                    if (SKIP_ADDR && shadow_valid_q && (shadow_addr_q == gnt_addr)) begin
                        state_d = ST_DATA;
                        a0_d    = 1'b1;
                        wdata_d = gnt_data;
                    end else begin
                        state_d = ST_ADDR;
                        wdata_d = {{(PSG_DATA_W-PSG_REG_W){1'b0}}, gnt_addr};
                    end
                end
            end
            ST_ADDR: begin
                shadow_addr_d  = addr_q;
                shadow_valid_d = 1'b1;
                state_d        = ST_DATA;
                a0_d           = 1'b1;
                wr_tick_d      = 1'b1;
                wdata_d        = data_q;
            end
            ST_DATA: begin
                if (GAP > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == 4'd0) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q - 4'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the captured request registers are reset too, so a dropped
    // in-flight write can never leak its fields into a later tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            addr_q         <= '0;
            data_q         <= '0;
            shadow_addr_q  <= '0;
            shadow_valid_q <= 1'b0;
            gap_cnt_q      <= '0;
            a0_q           <= 1'b0;
            wr_tick_q      <= 1'b0;
            wdata_q        <= '0;
        end else begin
            state_q        <= state_d;
            addr_q         <= addr_d;
            data_q         <= data_d;
            shadow_addr_q  <= shadow_addr_d;
            shadow_valid_q <= shadow_valid_d;
            gap_cnt_q      <= gap_cnt_d;
            a0_q           <= a0_d;
            wr_tick_q      <= wr_tick_d;
            wdata_q        <= wdata_d;
        end
    end

    assign a0      = a0_q;
    assign wr_tick = wr_tick_q;
    assign wdata   = wdata_q;
    assign busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_ay_write_arbiter.sv
// Directed bench: default-parameter instance plus a SKIP_ADDR=0 / GAP=3 instance.
module tb_ay_write_arbiter;

    logic       clk;
    logic       reset;

    logic       r0v, r1v, r0r, r1r;
    logic [3:0] r0a, r1a;
    logic [7:0] r0d, r1d;
    logic       a0, wr, busy;
    logic [7:0] wd;

    logic       r0v_b, r1v_b, r0r_b, r1r_b;
    logic [3:0] r0a_b, r1a_b;
    logic [7:0] r0d_b, r1d_b;
    logic       a0_b, wr_b, busy_b;
    logic [7:0] wd_b;

    int n_tests = 0;
    int n_fail  = 0;

    ay_write_arbiter dut (
        .clk(clk), .reset(reset),
        .req0_valid(r0v), .req0_addr(r0a), .req0_data(r0d), .req0_ready(r0r),
        .req1_valid(r1v), .req1_addr(r1a), .req1_data(r1d), .req1_ready(r1r),
        .a0(a0), .wr_tick(wr), .wdata(wd), .busy(busy)
    );

    ay_write_arbiter #(.SKIP_ADDR(1'b0), .GAP(3)) dut_b (
        .clk(clk), .reset(reset),
        .req0_valid(r0v_b), .req0_addr(r0a_b), .req0_data(r0d_b), .req0_ready(r0r_b),
        .req1_valid(r1v_b), .req1_addr(r1a_b), .req1_data(r1d_b), .req1_ready(r1r_b),
        .a0(a0_b), .wr_tick(wr_b), .wdata(wd_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Packed view {a0, wr_tick, wdata, busy, req0_ready, req1_ready}
    function automatic logic [12:0] pk(input int a, input int w, input int d,
                                       input int b, input int q0, input int q1);
        return {1'(a), 1'(w), 8'(d), 1'(b), 1'(q0), 1'(q1)};
    endfunction

    task automatic chk_a(input string tag, input logic [12:0] e);
        check(tag, {19'd0, a0, wr, wd, busy, r0r, r1r}, {19'd0, e});
    endtask

    task automatic chk_b(input string tag, input logic [12:0] e);
        check(tag, {19'd0, a0_b, wr_b, wd_b, busy_b, r0r_b, r1r_b}, {19'd0, e});
    endtask

    // Check 1 ns after the negedge where inputs were set, then advance a cycle.
    task automatic tick_a(input string tag, input logic [12:0] e);
        #1 chk_a(tag, e);
        @(negedge clk);
    endtask

    task automatic tick_b(input string tag, input logic [12:0] e);
        #1 chk_b(tag, e);
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b0;
        r0v = 1'b0; r0a = 4'd0; r0d = 8'h00;
        r1v = 1'b0; r1a = 4'd0; r1d = 8'h00;
        r0v_b = 1'b0; r0a_b = 4'd0; r0d_b = 8'h00;
        r1v_b = 1'b0; r1a_b = 4'd0; r1d_b = 8'h00;

        @(negedge clk);
        #1 chk_b("b_reset", pk(0, 0, 0, 0, 0, 0));
        tick_a("a_reset", pk(0, 0, 0, 0, 0, 0));

        // Single write from requester 0 straight after reset release
        reset = 1'b1;
        r0v = 1'b1; r0a = 4'd0; r0d = 8'h11;
        tick_a("t1_grant", pk(0, 0, 0, 0, 1, 0));
        r0v = 1'b0;
        tick_a("t1_addr", pk(0, 1, 8'h00, 1, 0, 0));
        tick_a("t1_data", pk(1, 1, 8'h11, 1, 0, 0));

        // Address skip on a repeated register
        r1v = 1'b1; r1a = 4'd8; r1d = 8'h10;
        tick_a("t2_grant1", pk(0, 0, 0, 0, 0, 1));
        r1v = 1'b0;
        tick_a("t2_addr1", pk(0, 1, 8'h08, 1, 0, 0));
        tick_a("t2_data1", pk(1, 1, 8'h10, 1, 0, 0));
        r1v = 1'b1; r1d = 8'h0F;
        tick_a("t2_grant2", pk(0, 0, 0, 0, 0, 1));
        r1v = 1'b0;
        tick_a("t2_skip_data", pk(1, 1, 8'h0F, 1, 0, 0));
        tick_a("t2_skip_idle", pk(0, 0, 0, 0, 0, 0));

        // Contention: last grant was requester 1, so requester 0 leads
        r0v = 1'b1; r0a = 4'd2; r0d = 8'hA0;
        r1v = 1'b1; r1a = 4'd3; r1d = 8'hB1;
        for (int w = 0; w < 4; w++) begin
            int g;
            g = w % 2;
            tick_a($sformatf("t3_grant%0d", w), pk(0, 0, 0, 0, int'(g == 0), int'(g == 1)));
            tick_a($sformatf("t3_addr%0d", w), pk(0, 1, (g == 1) ? 3 : 2, 1, 0, 0));
            tick_a($sformatf("t3_data%0d", w), pk(1, 1, (g == 1) ? 8'hB1 : 8'hA0, 1, 0, 0));
        end
        r0v = 1'b0; r1v = 1'b0;
        tick_a("t3_idle", pk(0, 0, 0, 0, 0, 0));

        // Stall compliance: requester 1 waits through a requester 0 write
        r0v = 1'b1; r0a = 4'd5; r0d = 8'h55;
        tick_a("t4_grant0", pk(0, 0, 0, 0, 1, 0));
        r0v = 1'b0;
        r1v = 1'b1; r1a = 4'd6; r1d = 8'h66;
        tick_a("t4_stall_addr", pk(0, 1, 8'h05, 1, 0, 0));
        tick_a("t4_stall_data", pk(1, 1, 8'h55, 1, 0, 0));
        tick_a("t4_grant1", pk(0, 0, 0, 0, 0, 1));
        r1v = 1'b0; r1a = 4'd15; r1d = 8'hEE;
        tick_a("t4_addr1", pk(0, 1, 8'h06, 1, 0, 0));
        tick_a("t4_data1", pk(1, 1, 8'h66, 1, 0, 0));

        // Reset during the address tick of (13, 0x0A)
        r0v = 1'b1; r0a = 4'd13; r0d = 8'h0A;
        tick_a("t5_grant", pk(0, 0, 0, 0, 1, 0));
        r0v = 1'b0;
        #1 chk_a("t5_addr_pre", pk(0, 1, 8'h0D, 1, 0, 0));
        reset = 1'b0;
        #1 chk_a("t5_rst_drop", pk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        // last_grant back to 1: requester 0 wins the tie
        r0v = 1'b1; r0a = 4'd13; r0d = 8'h0B;
        r1v = 1'b1; r1a = 4'd9;  r1d = 8'h99;
        tick_a("t5_tie_grant0", pk(0, 0, 0, 0, 1, 0));
        r0v = 1'b0;
        tick_a("t5_addr13", pk(0, 1, 8'h0D, 1, 0, 0));
        tick_a("t5_data13", pk(1, 1, 8'h0B, 1, 0, 0));
        tick_a("t5_grant1", pk(0, 0, 0, 0, 0, 1));
        r1v = 1'b0;
        tick_a("t5_addr9", pk(0, 1, 8'h09, 1, 0, 0));
        tick_a("t5_data9", pk(1, 1, 8'h99, 1, 0, 0));

        // Reset in IDLE invalidates a freshly latched shadow address
        r0v = 1'b1; r0a = 4'd7; r0d = 8'h70;
        tick_a("t6_grant", pk(0, 0, 0, 0, 1, 0));
        r0v = 1'b0;
        tick_a("t6_addr", pk(0, 1, 8'h07, 1, 0, 0));
        tick_a("t6_data", pk(1, 1, 8'h70, 1, 0, 0));
        reset = 1'b0;
        #1 chk_a("t6_rst_idle", pk(0, 0, 0, 0, 0, 0));
        @(negedge clk);
        reset = 1'b1;
        r0v = 1'b1; r0d = 8'h71;
        tick_a("t6_grant2", pk(0, 0, 0, 0, 1, 0));
        r0v = 1'b0;
        tick_a("t6_addr_again", pk(0, 1, 8'h07, 1, 0, 0));
        tick_a("t6_data2", pk(1, 1, 8'h71, 1, 0, 0));
        tick_a("t6_idle", pk(0, 0, 0, 0, 0, 0));

        // No-skip, GAP=3 instance: two queued writes to register 8
        r1v_b = 1'b1; r1a_b = 4'd8; r1d_b = 8'h10;
        tick_b("b_grant1", pk(0, 0, 0, 0, 0, 1));
        r1d_b = 8'h0F;
        tick_b("b_addr1", pk(0, 1, 8'h08, 1, 0, 0));
        tick_b("b_data1", pk(1, 1, 8'h10, 1, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tick_b($sformatf("b_gap1_%0d", i), pk(0, 0, 0, 1, 0, 0));
        end
        tick_b("b_grant2", pk(0, 0, 0, 0, 0, 1));
        r1v_b = 1'b0;
        tick_b("b_addr2_noskip", pk(0, 1, 8'h08, 1, 0, 0));
        tick_b("b_data2", pk(1, 1, 8'h0F, 1, 0, 0));
        for (int i = 0; i < 3; i++) begin
            tick_b($sformatf("b_gap2_%0d", i), pk(0, 0, 0, 1, 0, 0));
        end
        tick_b("b_idle", pk(0, 0, 0, 0, 0, 0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ay_write_arbiter.md
# ay_write_arbiter

Arbitrates register writes to the `ay3891x` PSG core between two requesters: the CPU I/O path and a hardware music/envelope sequencer. Each granted request becomes the PSG's two-tick bus sequence: address latch with `a0=0`, then data write with `a0=1`. A latched-address shadow can skip redundant address ticks. The block sits between the requesters and the `a0`/`wr_tick`/`wdata` inputs of `ay3891x`; reads bypass it.

## Interface
- `SKIP_ADDR`, default 1. When 1, omit the address tick if the target register equals the PSG's currently latched address.
- `GAP`, default 0. Idle cycles (0–15) inserted after each completed write, before the next grant.
- `clk`  input  1  system clock.
- `reset`  input  1  asynchronous, active-low reset.
- `req0_valid`  input  1  requester 0 (CPU) has a write pending.
- `req0_addr`  input  4  requester 0 target PSG register.
- `req0_data`  input  8  requester 0 write data.
- `req0_ready`  output  1  requester 0 request accepted this cycle.
- `req1_valid`, `req1_addr`, `req1_data`, `req1_ready`: same as requester 0, for requester 1 (sequencer).
- `a0`  output  1  to PSG: 0 = address tick, 1 = data tick.
- `wr_tick`  output  1  to PSG write strobe, exactly one cycle per tick.
- `wdata`  output  8  to PSG write data.
- `busy`  output  1  high whenever state is not IDLE.

## Operation
- **States:** IDLE, ADDR, DATA, GAP.
- **Grant:**
  - Taken only in IDLE, while at least one `reqN_valid` is high.
  - The selected `reqN_ready` is combinational and high for that single cycle.
  - `addr`/`data` are captured at the same edge.
  - Handshake completes when valid and ready are both high. The requester must hold its fields stable while valid is high and not yet granted.
- **Arbitration:** round-robin with a 1-bit `last_grant`.
  - When both requesters are valid, grant the one not granted last.
  - Reset value of `last_grant` is 1, so requester 0 wins the first tie.
  - A single valid requester is always granted.
- **After a grant:**
  - Go to DATA when `SKIP_ADDR=1`, `shadow_valid=1` and `shadow_addr == captured addr`.
  - Otherwise go to ADDR.
- **ADDR:** `a0=0`, `wr_tick=1`, `wdata={4'h0, addr}`. Update `shadow_addr`, set `shadow_valid`, go to DATA.
- **DATA:** `a0=1`, `wr_tick=1`, `wdata=data`. Go to GAP if `GAP>0`, else IDLE.
- **GAP:** a 4-bit counter counts `GAP` cycles, then the state returns to IDLE.
- **Output defaults:** in IDLE and GAP, `wr_tick=0`, `a0=0`, `wdata=0`. `a0`, `wr_tick` and `wdata` are registered.
- **Reset (async assert, any state, including mid-transaction):**
  - State returns to IDLE; outputs are 0.
  - `shadow_valid` clears and `last_grant` is 1.
  - An in-flight write is dropped and is not retried. Its requester already saw ready.
- **Shadow:** `shadow_valid` clears on reset only. The PSG is reset from the same net, so its latched address is also lost.
- **Requests in other states:** a request asserted in a non-IDLE state waits. Ready stays low and no request is lost.

## Timing
- Request valid in IDLE at cycle k: ready high in cycle k.
- Address tick outputs present in cycle k+1, data tick in cycle k+2, IDLE again in cycle k+3 (`GAP=0`).
- Throughput at `GAP=0`:
  - 3 cycles per write without skip.
  - 2 cycles per write with skip (data tick in k+1, IDLE in k+2).
- Back-to-back stream: the next grant can occur in the first IDLE cycle, so ticks from consecutive writes are never adjacent across a grant cycle.
- Simultaneous valid on both requesters in the same IDLE cycle: only one ready is high. The loser is granted at the next IDLE.
- Reset deassertion: the first grant is possible in the first clock edge after release.

## Structure
- A shared package holds:
  - the state encoding (IDLE=0, ADDR=1, DATA=2, GAP=3);
  - `PSG_REG_W = 4` and `PSG_DATA_W = 8`.
- One sub-module: `rr_arbiter2`, a two-way round-robin grant with a `last_grant` register and an update enable.
- FSM, shadow and gap counter live in the top module.

## Test plan
- **Single write, requester 0:** (0, 0x11) after reset gives an address tick with `wdata=0x00`, `a0=0`, then a data tick with `wdata=0x11`, `a0=1`, on consecutive cycles. `req0_ready` pulses once.
- **Address skip:** writes (8, 0x10) then (8, 0x0F) from requester 1. The second produces only a data tick. With `SKIP_ADDR=0` both writes produce address ticks.
- **Contention:** both requesters valid continuously with distinct addresses. Grants alternate 0,1,0,1. Each write spans exactly 3 cycles (`GAP=0`).
- **Gap spacing:** `GAP=3`, two queued writes. Exactly 3 idle cycles, with `busy=1` and `wr_tick=0`, separate the first data tick from the next grant.
- **Mid-operation reset:** assert reset in the ADDR cycle of (13, 0x0A). `wr_tick` drops immediately. After release, a write to register 13 issues an address tick, because the shadow was invalidated.
- **Stall compliance:** `req1_valid` held during a requester 0 transaction. `req1_ready` stays 0 until IDLE. Captured data equals the held `req1_data`.
